// File: rtl/fpmult_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : fpmult_share_arb
// Brief    : Round-robin sharing of one fixed-latency FP16 multiplier between
//            NUM_REQ requesters, with tag tracking to route products back.
// Revision : 1.0 - initial release
// ============================================================================
module fpmult_share_arb #(
    parameter int NUM_REQ      = 4,
    parameter int DWIDTH       = 16,
    parameter int MULT_LATENCY = 5,
    parameter int MAX_OUT      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DWIDTH-1:0] req_a,
    input  logic [NUM_REQ*DWIDTH-1:0] req_b,
    input  logic                      hold,
    output logic [DWIDTH-1:0]         mult_a,
    output logic [DWIDTH-1:0]         mult_b,
    input  logic [DWIDTH-1:0]         mult_result,
    input  logic [4:0]                mult_flags,
    output logic [NUM_REQ-1:0]        res_valid,
    output logic [DWIDTH-1:0]         res_data,
    output logic [4:0]                res_flags,
    output logic                      busy
);

    localparam int c_IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CW  = $clog2(MAX_OUT + 1);

    logic [c_IDW-1:0]        r_rr_ptr;
    logic [c_CW-1:0]         r_out_cnt [NUM_REQ];
    logic [MULT_LATENCY-1:0] r_tag_vld;
    logic [c_IDW-1:0]        r_tag_id  [MULT_LATENCY];

    logic [NUM_REQ-1:0] w_elig;
    logic               w_issue;
    logic [c_IDW-1:0]   w_win;
    int                 w_idx;
    logic               w_ret;
    logic [c_IDW-1:0]   w_ret_id;

    // Counts are registered, so a return frees a slot only from the next cycle.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            assign w_elig[gi] = req_valid[gi] && !hold && !rst &&
                                (r_out_cnt[gi] < c_CW'(MAX_OUT));
        end
    endgenerate

    always_comb begin
        w_issue = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_issue && w_elig[w_idx]) begin
                w_issue = 1'b1;
                w_win   = c_IDW'(w_idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_issue) req_ready[w_win] = 1'b1;
    end

    assign mult_a = w_issue ? req_a[w_win*DWIDTH +: DWIDTH] : '0;
    assign mult_b = w_issue ? req_b[w_win*DWIDTH +: DWIDTH] : '0;

    // The oldest tag lines up with mult_result in the same cycle.
    assign w_ret    = r_tag_vld[MULT_LATENCY-1];
    assign w_ret_id = r_tag_id[MULT_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= c_IDW'(NUM_REQ - 1);
            r_tag_vld <= '0;
            for (int i = 0; i < MULT_LATENCY; i++) r_tag_id[i] <= '0;
            for (int i = 0; i < NUM_REQ; i++) r_out_cnt[i] <= '0;
            res_valid <= '0;
            res_data  <= '0;
            res_flags <= '0;
        end else begin
            r_tag_vld[0] <= w_issue;
            r_tag_id[0]  <= w_win;
            for (int i = 1; i < MULT_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end

            if (w_issue) r_rr_ptr <= w_win;

            res_valid <= '0;
            if (w_ret) begin
                res_valid[w_ret_id] <= 1'b1;
                res_data            <= mult_result;
                res_flags           <= mult_flags;
            end

            for (int i = 0; i < NUM_REQ; i++) begin
                if ((w_issue && w_win == c_IDW'(i)) && !(w_ret && w_ret_id == c_IDW'(i)))
                    r_out_cnt[i] <= r_out_cnt[i] + c_CW'(1);
                else if (!(w_issue && w_win == c_IDW'(i)) && (w_ret && w_ret_id == c_IDW'(i)))
                    r_out_cnt[i] <= r_out_cnt[i] - c_CW'(1);
            end
        end
    end

    assign busy = (|r_tag_vld) | (|res_valid);

endmodule
`default_nettype wire
